// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder slice.
package mem_pkg;
  localparam int WORD_W    = 32;
  localparam int NUM_BYTES = WORD_W / 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

  // Request fields held from acceptance until the array access in RESP.
  typedef struct packed {
    logic                 we;
    logic                 err;
    logic [WORD_W-1:0]    wdata;
    logic [NUM_BYTES-1:0] wstrb;
  } mem_req_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/mem_array.sv
// Word-indexed storage: byte-strobed synchronous write, registered read, no reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [AW-1:0]        idx,
  input  logic [WORD_W-1:0]    wdata,
  input  logic [NUM_BYTES-1:0] wstrb,
  output logic [WORD_W-1:0]    rdata
);
  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < NUM_BYTES; b++)
          if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end else begin
        rdata <= mem[idx];
      end
    end
  end
endmodule

// File: rtl/mem_responder.sv
// Memory responder: valid/ready request, fixed-latency response pulse,
// byte-strobed stores, alignment and range checking.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [WORD_W-1:0]    req_wdata,
  input  logic [NUM_BYTES-1:0] req_wstrb,
  output logic                 rsp_valid,
  output logic [WORD_W-1:0]    rsp_rdata,
  output logic                 rsp_err
);
  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          CW      = 4;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

  resp_state_t       state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              accept, go_resp;
  logic              rsp_err_q, rd_sel;
  mem_req_t          req_in, req_q, req_cur;
  logic [AW-1:0]     idx_in, idx_q, idx_cur;
  logic [WORD_W-1:0] arr_rdata;

  assign req_ready = rst_n && (state != WAIT);
  assign accept    = req_valid && req_ready;

  assign req_in.we    = req_we;
  assign req_in.err   = is_misaligned(req_addr) || (req_addr[31:2] >= DEPTH_W);
  assign req_in.wdata = req_wdata;
  assign req_in.wstrb = req_wstrb;
  assign idx_in       = req_addr[AW+1:2];

  // With single-cycle latency the array is accessed on the acceptance edge
  // itself, so it must see the live request rather than the latch.
  assign req_cur = (LATENCY == 1) ? req_in : req_q;
  assign idx_cur = (LATENCY == 1) ? idx_in : idx_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: begin
        if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
        else        state_nxt = IDLE;
      end
      WAIT:    if (cnt <= CW'(1)) state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  assign go_resp = (state_nxt == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_q     <= '0;
      idx_q     <= '0;
      rsp_err_q <= 1'b0;
      rd_sel    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_q <= req_in;
        idx_q <= idx_in;
        cnt   <= CW'(LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - CW'(1);
      end
      rsp_err_q <= go_resp && req_cur.err;
      rd_sel    <= go_resp && !req_cur.we && !req_cur.err;
    end
  end

  // rst_n gate keeps a store that was in flight from landing while reset is held.
  mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_mem_array (
    .clk   (clk),
    .en    (go_resp && !req_cur.err && rst_n),
    .we    (req_cur.we),
    .idx   (idx_cur),
    .wdata (req_cur.wdata),
    .wstrb (req_cur.wstrb),
    .rdata (arr_rdata)
  );

  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rd_sel ? arr_rdata : '0;
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder side of the CPU's memory request interface: unified instruction/data word memory with a valid/ready request handshake and a fixed-latency response pulse.
- Sits between the multicycle core's fetch/load/store initiator and the storage array.
- Adds configurable wait states, byte-strobed writes, alignment checks and range checks, so the core's FSM can be exercised against realistic memory timing.

Parameters:
- DEPTH_WORDS, 64: number of 32-bit words; word index = req_addr[31:2].
- LATENCY, 1: cycles from the acceptance edge to rsp_valid high; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept this cycle.
- req_we  in  1  1 = store, 0 = load/fetch.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_wstrb  in  4  byte enables for store; bit i gates bits 8i+7:8i.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load data, valid only while rsp_valid=1.
- rsp_err  out  1  request was rejected (misaligned or out of range), valid with rsp_valid.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; counter 0; rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 while rst_n=0. Storage array is NOT cleared.
- Reset mid-operation: any latched request is dropped and a pending store is not committed.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1.
  - req_valid & req_ready at an edge = acceptance. The edge latches we/addr/wdata/wstrb and loads the counter with LATENCY-1.
  - On acceptance: next state is RESP if LATENCY=1, else WAIT.
  - WAIT: req_ready=0. Counter decrements each edge; at counter=1 the next state is RESP.
  - RESP: rsp_valid=1 for exactly one cycle. req_ready=1, so a back-to-back acceptance is allowed.
  - Leaving RESP: go to WAIT or RESP if a new request is accepted in that cycle, else IDLE.
  - Sustained throughput with LATENCY=1 is one request per cycle after the first.
- Commit timing: the array read and the array write both occur at the edge entering RESP.
  - rsp_rdata is registered from the array at that edge.
  - A store commits its byte lanes at that edge.
- Store response: rsp_rdata=0.
- Read-after-write ordering: a load accepted in the RESP cycle of a store to the same word returns the post-store value.
- Errors are evaluated at acceptance:
  - misaligned: req_addr[1:0] != 0.
  - out of range: req_addr[31:2] >= DEPTH_WORDS.
  - Effect: no write, rsp_rdata=0, rsp_err=1. The response still arrives with normal LATENCY timing.
- req_wstrb=0 on a store: legal no-op write, rsp_err=0.
- Request inputs are sampled only at acceptance. Changes while req_ready=0 are ignored.
- rsp_valid has no backpressure; the initiator must always take the pulse.
- Storage array is named mem and is word-indexed. Benches preload programs and data by hierarchical reference before the first clock edge.

Decomposition:
- Package mem_pkg:
  - state enum resp_state_t {IDLE, WAIT, RESP}.
  - localparam word width 32, byte-lane count 4.
  - function is_misaligned(addr).
- Sub-module mem_array: DEPTH_WORDS x 32 storage named mem, byte-strobed synchronous write and synchronous registered read on the same port, no reset.
- mem_responder owns the FSM, latency counter, request latch and error logic.

Test Plan:
- Preload mem[3]=0xDEADBEEF, LATENCY=1; load addr 0x0C -> rsp_valid exactly 1 cycle after acceptance, rsp_rdata=0xDEADBEEF, rsp_err=0.
- LATENCY=3; store addr 0x10, wdata=0x11223344, wstrb=0b0101, with mem[4] preloaded 0xAABBCCDD -> req_ready low for 2 cycles, rsp_valid on the 3rd; then load 0x10 returns 0xAA22CC44.
- LATENCY=1 back-to-back: store 0x08 (0x5, wstrb=0xF) accepted, then load 0x08 accepted in its RESP cycle -> second response 1 cycle later with rdata=0x00000005; two rsp_valid pulses on consecutive cycles.
- Load 0x06 (misaligned) and load 0x100 with DEPTH_WORDS=64 (out of range) -> each returns rsp_err=1, rdata=0. A store to 0x100 leaves all words unchanged.
- LATENCY=4; store 0x00 (0xFFFFFFFF) accepted, rst_n pulsed low during WAIT -> outputs drop to 0 immediately, mem[0] keeps its preload value, FSM is in IDLE and req_ready=1 after release.
- req_valid held high with changing addr while in WAIT -> only the address present at acceptance is served.
